// File: rtl/load_store_queue_pkg.sv
// Shared definitions for the load/store queue: default widths, access-size
// codes and the memory-side FSM state encoding.
package load_store_queue_pkg;

  localparam int unsigned DEPTH_DEF  = 8;
  localparam int unsigned ROB_W_DEF  = 4;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    LEN_BYTE = 2'b01,
    LEN_HALF = 2'b10,
    LEN_WORD = 2'b11
  } lsq_len_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BUSY  = 2'b01,
    ST_DRAIN = 2'b10
  } lsq_state_e;

endpackage

// File: rtl/lsq_load_extend.sv
// Sign/zero extension of raw load data according to the access size.
module lsq_load_extend
  import load_store_queue_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic [1:0]        len,
  input  logic              is_unsigned,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] result_c
);

  always_comb begin
    result_c = data;
    case (lsq_len_e'(len))
      LEN_BYTE: result_c = is_unsigned ? {{(DATA_W-8){1'b0}}, data[7:0]}
                                       : {{(DATA_W-8){data[7]}}, data[7:0]};
      LEN_HALF: result_c = is_unsigned ? {{(DATA_W-16){1'b0}}, data[15:0]}
                                       : {{(DATA_W-16){data[15]}}, data[15:0]};
      default:  result_c = data;
    endcase
  end

endmodule

// File: rtl/load_store_queue.sv
// In-order load/store queue: operand wakeup, store commit gating, and a
// single outstanding memory access with flush draining.
module load_store_queue
  import load_store_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned ROB_W  = ROB_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              clr_in,
  input  logic              issue_valid,
  input  logic [ROB_W-1:0]  issue_rob_index,
  input  logic              issue_is_store,
  input  logic [1:0]        issue_len,
  input  logic              issue_unsigned,
  input  logic [DATA_W-1:0] issue_rs1_val,
  input  logic [DATA_W-1:0] issue_rs2_val,
  input  logic [ROB_W-1:0]  issue_rs1_depend,
  input  logic [ROB_W-1:0]  issue_rs2_depend,
  input  logic [DATA_W-1:0] issue_imm,
  output logic              lsq_full,
  input  logic              alu_valid,
  input  logic [ROB_W-1:0]  alu_rob_index,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              commit_valid,
  input  logic [ROB_W-1:0]  commit_rob_index,
  output logic              mc_req,
  output logic              mc_is_store,
  output logic [1:0]        mc_len,
  output logic [DATA_W-1:0] mc_addr,
  output logic [DATA_W-1:0] mc_wdata,
  input  logic              mc_done,
  input  logic [DATA_W-1:0] mc_rdata,
  output logic              lsq_out_valid,
  output logic [DATA_W-1:0] lsq_out_result,
  output logic [ROB_W-1:0]  lsq_out_rob_index
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ROB_W-1:0]  rob;
    logic              is_store;
    logic [1:0]        len;
    logic              is_unsigned;
    logic [DATA_W-1:0] rs1_val;
    logic [DATA_W-1:0] rs2_val;
    logic [ROB_W-1:0]  rs1_dep;
    logic [ROB_W-1:0]  rs2_dep;
    logic [DATA_W-1:0] imm;
    logic              committed;
  } entry_t;

  entry_t            q [DEPTH];
  logic [PTR_W-1:0]  head_q, tail_q;
  logic [CNT_W-1:0]  count_q, count_d;
  lsq_state_e        state_q, state_d;
  entry_t            head_e, new_e;
  logic              push, pop, head_ok;
  logic              mc_req_d, mc_is_store_d;
  logic [1:0]        mc_len_d;
  logic [DATA_W-1:0] mc_addr_d, mc_wdata_d, out_result_d, ext_c;
  logic              out_valid_d;
  logic [ROB_W-1:0]  out_rob_d, fl_rob_q, fl_rob_d;
  logic              fl_uns_q, fl_uns_d;

  // Tag 0 means "ready", so it never matches a broadcast.
  function automatic logic hit(input logic [ROB_W-1:0] dep, input logic v,
                               input logic [ROB_W-1:0] tag);
    return v && (dep != '0) && (dep == tag);
  endfunction

  // Capture broadcast operands and latch store commits into one entry.
  function automatic entry_t wake(input entry_t e);
    entry_t r;
    r = e;
    if (hit(e.rs1_dep, alu_valid, alu_rob_index)) begin
      r.rs1_val = alu_result;
      r.rs1_dep = '0;
    end else if (hit(e.rs1_dep, lsq_out_valid, lsq_out_rob_index)) begin
      r.rs1_val = lsq_out_result;
      r.rs1_dep = '0;
    end
    if (hit(e.rs2_dep, alu_valid, alu_rob_index)) begin
      r.rs2_val = alu_result;
      r.rs2_dep = '0;
    end else if (hit(e.rs2_dep, lsq_out_valid, lsq_out_rob_index)) begin
      r.rs2_val = lsq_out_result;
      r.rs2_dep = '0;
    end
    if (commit_valid && e.is_store && (e.rob == commit_rob_index))
      r.committed = 1'b1;
    return r;
  endfunction

  always_comb begin
    new_e             = '0;
    new_e.rob         = issue_rob_index;
    new_e.is_store    = issue_is_store;
    new_e.len         = issue_len;
    new_e.is_unsigned = issue_unsigned;
    new_e.rs1_val     = issue_rs1_val;
    new_e.rs2_val     = issue_rs2_val;
    new_e.rs1_dep     = issue_rs1_depend;
    new_e.rs2_dep     = issue_rs2_depend;
    new_e.imm         = issue_imm;
  end

  assign head_e  = q[head_q];
  assign head_ok = (count_q != '0) && (head_e.rs1_dep == '0) && (head_e.rs2_dep == '0) &&
                   (!head_e.is_store || head_e.committed ||
                    (commit_valid && (commit_rob_index == head_e.rob)));
  assign push    = issue_valid && !lsq_full && !clr_in;
  assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);

  // Entry storage and queue pointers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < int'(DEPTH); i++) q[i] <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      lsq_full <= 1'b0;
    end else if (rdy_in) begin
      for (int i = 0; i < int'(DEPTH); i++) q[i] <= wake(q[i]);
      if (push) q[tail_q] <= wake(new_e);
      if (clr_in) begin
        head_q   <= '0;
        tail_q   <= '0;
        count_q  <= '0;
        lsq_full <= 1'b0;
      end else begin
        head_q   <= head_q + PTR_W'(pop);
        tail_q   <= tail_q + PTR_W'(push);
        count_q  <= count_d;
        lsq_full <= (count_d == CNT_W'(DEPTH));
      end
    end
  end

  lsq_load_extend #(.DATA_W(DATA_W)) u_load_extend (
    .len         (mc_len),
    .is_unsigned (fl_uns_q),
    .data        (mc_rdata),
    .result_c    (ext_c)
  );

  // FSM state and registered memory/result outputs.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q           <= ST_IDLE;
      mc_req            <= 1'b0;
      mc_is_store       <= 1'b0;
      mc_len            <= '0;
      mc_addr           <= '0;
      mc_wdata          <= '0;
      lsq_out_valid     <= 1'b0;
      lsq_out_result    <= '0;
      lsq_out_rob_index <= '0;
      fl_rob_q          <= '0;
      fl_uns_q          <= 1'b0;
    end else if (rdy_in) begin
      state_q           <= state_d;
      mc_req            <= mc_req_d;
      mc_is_store       <= mc_is_store_d;
      mc_len            <= mc_len_d;
      mc_addr           <= mc_addr_d;
      mc_wdata          <= mc_wdata_d;
      lsq_out_valid     <= out_valid_d;
      lsq_out_result    <= out_result_d;
      lsq_out_rob_index <= out_rob_d;
      fl_rob_q          <= fl_rob_d;
      fl_uns_q          <= fl_uns_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pop           = 1'b0;
    mc_req_d      = mc_req;
    mc_is_store_d = mc_is_store;
    mc_len_d      = mc_len;
    mc_addr_d     = mc_addr;
    mc_wdata_d    = mc_wdata;
    out_valid_d   = 1'b0;
    out_result_d  = lsq_out_result;
    out_rob_d     = lsq_out_rob_index;
    fl_rob_d      = fl_rob_q;
    fl_uns_d      = fl_uns_q;
    case (state_q)
      ST_IDLE: begin
        if (head_ok && !clr_in) begin
          pop           = 1'b1;
          mc_req_d      = 1'b1;
          mc_is_store_d = head_e.is_store;
          mc_len_d      = head_e.len;
          mc_addr_d     = head_e.rs1_val + head_e.imm;
          mc_wdata_d    = head_e.rs2_val;
          fl_rob_d      = head_e.rob;
          fl_uns_d      = head_e.is_unsigned;
          state_d       = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (mc_done) begin
          mc_req_d = 1'b0;
          state_d  = ST_IDLE;
          if (!clr_in) begin
            out_valid_d  = 1'b1;
            out_result_d = mc_is_store ? '0 : ext_c;
            out_rob_d    = fl_rob_q;
          end
        end else if (clr_in) begin
          state_d = ST_DRAIN;
        end
      end
      // Flushed access: finish the handshake, drop the result.
      ST_DRAIN: begin
        if (mc_done) begin
          mc_req_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_queue.sv
// Directed bench for load_store_queue: loads, extension, store wakeup/commit,
// fill/wrap, flush during store, rdy_in freeze and asynchronous reset.
module tb_load_store_queue;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clr_in;
  logic        issue_valid, issue_is_store, issue_unsigned;
  logic [3:0]  issue_rob_index, issue_rs1_depend, issue_rs2_depend;
  logic [1:0]  issue_len;
  logic [31:0] issue_rs1_val, issue_rs2_val, issue_imm;
  logic        lsq_full;
  logic        alu_valid;
  logic [3:0]  alu_rob_index;
  logic [31:0] alu_result;
  logic        commit_valid;
  logic [3:0]  commit_rob_index;
  logic        mc_req, mc_is_store;
  logic [1:0]  mc_len;
  logic [31:0] mc_addr, mc_wdata;
  logic        mc_done;
  logic [31:0] mc_rdata;
  logic        lsq_out_valid;
  logic [31:0] lsq_out_result;
  logic [3:0]  lsq_out_rob_index;

  int checks = 0;
  int errors = 0;

  load_store_queue dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clr_in(clr_in),
    .issue_valid(issue_valid), .issue_rob_index(issue_rob_index),
    .issue_is_store(issue_is_store), .issue_len(issue_len),
    .issue_unsigned(issue_unsigned), .issue_rs1_val(issue_rs1_val),
    .issue_rs2_val(issue_rs2_val), .issue_rs1_depend(issue_rs1_depend),
    .issue_rs2_depend(issue_rs2_depend), .issue_imm(issue_imm),
    .lsq_full(lsq_full), .alu_valid(alu_valid), .alu_rob_index(alu_rob_index),
    .alu_result(alu_result), .commit_valid(commit_valid),
    .commit_rob_index(commit_rob_index), .mc_req(mc_req),
    .mc_is_store(mc_is_store), .mc_len(mc_len), .mc_addr(mc_addr),
    .mc_wdata(mc_wdata), .mc_done(mc_done), .mc_rdata(mc_rdata),
    .lsq_out_valid(lsq_out_valid), .lsq_out_result(lsq_out_result),
    .lsq_out_rob_index(lsq_out_rob_index)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #100000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk_in);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] rob, input logic st, input logic [1:0] len,
                       input logic uns, input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [3:0] d1, input logic [3:0] d2, input logic [31:0] imm);
    issue_valid = 1'b1; issue_rob_index = rob; issue_is_store = st; issue_len = len;
    issue_unsigned = uns; issue_rs1_val = rs1; issue_rs2_val = rs2;
    issue_rs1_depend = d1; issue_rs2_depend = d2; issue_imm = imm;
    step();
    issue_valid = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (mc_req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk(tag, 32'(mc_req), 32'd1);
  endtask

  task automatic complete(input logic [31:0] rdata);
    mc_done = 1'b1; mc_rdata = rdata;
    step();
    mc_done = 1'b0;
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; clr_in = 1'b0; issue_valid = 1'b0;
    issue_rob_index = '0; issue_is_store = 1'b0; issue_len = '0; issue_unsigned = 1'b0;
    issue_rs1_val = '0; issue_rs2_val = '0; issue_rs1_depend = '0; issue_rs2_depend = '0;
    issue_imm = '0; alu_valid = 1'b0; alu_rob_index = '0; alu_result = '0;
    commit_valid = 1'b0; commit_rob_index = '0; mc_done = 1'b0; mc_rdata = '0;
    repeat (2) step();
    rst_in = 1'b0;
    chk("rst_mc_req", 32'(mc_req), 32'd0);
    chk("rst_out_valid", 32'(lsq_out_valid), 32'd0);
    chk("rst_full", 32'(lsq_full), 32'd0);
    chk("rst_addr", mc_addr, 32'd0);

    // LW tag 3 at 0x100+4
    issue(4'd3, 1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 4'd0, 4'd0, 32'd4);
    wait_req("lw_req");
    chk("lw_addr", mc_addr, 32'h104);
    chk("lw_len", 32'(mc_len), 32'd3);
    chk("lw_is_store", 32'(mc_is_store), 32'd0);
    complete(32'hDEADBEEF);
    chk("lw_req_drop", 32'(mc_req), 32'd0);
    chk("lw_out_valid", 32'(lsq_out_valid), 32'd1);
    chk("lw_result", lsq_out_result, 32'hDEADBEEF);
    chk("lw_tag", 32'(lsq_out_rob_index), 32'd3);
    step();
    chk("lw_out_pulse", 32'(lsq_out_valid), 32'd0);

    // LB, LBU, LH sign/zero extension
    issue(4'd6, 1'b0, 2'b01, 1'b0, 32'h200, 32'h0, 4'd0, 4'd0, 32'd0);
    wait_req("lb_req");
    chk("lb_len", 32'(mc_len), 32'd1);
    complete(32'h00000080);
    chk("lb_result", lsq_out_result, 32'hFFFFFF80);
    issue(4'd7, 1'b0, 2'b01, 1'b1, 32'h200, 32'h0, 4'd0, 4'd0, 32'd0);
    wait_req("lbu_req");
    complete(32'h00000080);
    chk("lbu_result", lsq_out_result, 32'h00000080);
    chk("lbu_tag", 32'(lsq_out_rob_index), 32'd7);
    issue(4'd1, 1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 4'd0, 4'd0, 32'd2);
    wait_req("lh_req");
    complete(32'h12348001);
    chk("lh_result", lsq_out_result, 32'hFFFF8001);

    // SW tag 5 waits for ALU tag 2 and then for its commit
    issue(4'd5, 1'b1, 2'b11, 1'b0, 32'h300, 32'h0, 4'd0, 4'd2, 32'd8);
    repeat (3) begin step(); chk("sw_wait_dep", 32'(mc_req), 32'd0); end
    alu_valid = 1'b1; alu_rob_index = 4'd2; alu_result = 32'h55;
    step();
    alu_valid = 1'b0;
    repeat (2) begin step(); chk("sw_wait_commit", 32'(mc_req), 32'd0); end
    commit_valid = 1'b1; commit_rob_index = 4'd5;
    step();
    commit_valid = 1'b0;
    chk("sw_req", 32'(mc_req), 32'd1);
    chk("sw_is_store", 32'(mc_is_store), 32'd1);
    chk("sw_wdata", mc_wdata, 32'h55);
    chk("sw_addr", mc_addr, 32'h308);
    complete(32'hFFFFFFFF);
    chk("sw_out_valid", 32'(lsq_out_valid), 32'd1);
    chk("sw_result", lsq_out_result, 32'd0);
    chk("sw_tag", 32'(lsq_out_rob_index), 32'd5);

    // Fill to DEPTH twice; each round wraps the pointers
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 8; i++)
        issue(4'(8 + i), 1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 4'd1, 4'd0, 32'(4 * i));
      chk("fill_full", 32'(lsq_full), 32'd1);
      issue(4'd7, 1'b0, 2'b11, 1'b0, 32'h9000, 32'h0, 4'd0, 4'd0, 32'd0);
      chk("full_hold", 32'(lsq_full), 32'd1);
      chk("full_no_req", 32'(mc_req), 32'd0);
      alu_valid = 1'b1; alu_rob_index = 4'd1; alu_result = 32'h1000;
      step();
      alu_valid = 1'b0;
      wait_req("fill_first_req");
      chk("pop_not_full", 32'(lsq_full), 32'd0);
      for (int i = 0; i < 8; i++) begin
        wait_req("fill_req");
        chk("fill_addr", mc_addr, 32'h1000 + 32'(4 * i));
        complete(32'(i));
        chk("fill_tag", 32'(lsq_out_rob_index), 32'(8 + i));
        chk("fill_result", lsq_out_result, 32'(i));
      end
      repeat (4) step();
      chk("dropped_issue", 32'(mc_req), 32'd0);
    end

    // SW in flight, flush: drain, no result, queue emptied; LW issued in DRAIN
    issue(4'd4, 1'b1, 2'b11, 1'b0, 32'h400, 32'hAA, 4'd0, 4'd0, 32'd0);
    commit_valid = 1'b1; commit_rob_index = 4'd4;
    step();
    commit_valid = 1'b0;
    chk("clr_sw_req", 32'(mc_req), 32'd1);
    clr_in = 1'b1;
    step();
    clr_in = 1'b0;
    issue(4'd6, 1'b0, 2'b11, 1'b0, 32'h500, 32'h0, 4'd0, 4'd0, 32'h10);
    repeat (2) begin
      step();
      chk("drain_req_held", 32'(mc_req), 32'd1);
      chk("drain_addr_held", mc_addr, 32'h400);
      chk("drain_no_out", 32'(lsq_out_valid), 32'd0);
    end
    complete(32'h0);
    chk("drain_req_drop", 32'(mc_req), 32'd0);
    chk("drain_suppress", 32'(lsq_out_valid), 32'd0);
    wait_req("post_clr_req");
    chk("post_clr_addr", mc_addr, 32'h510);
    complete(32'hCAFEF00D);
    chk("post_clr_valid", 32'(lsq_out_valid), 32'd1);
    chk("post_clr_tag", 32'(lsq_out_rob_index), 32'd6);
    chk("post_clr_result", lsq_out_result, 32'hCAFEF00D);
    repeat (3) step();
    chk("queue_empty", 32'(mc_req), 32'd0);

    // Issue together with clr_in is discarded
    clr_in = 1'b1;
    issue(4'd9, 1'b0, 2'b11, 1'b0, 32'h600, 32'h0, 4'd0, 4'd0, 32'd0);
    clr_in = 1'b0;
    repeat (3) step();
    chk("clr_issue_drop", 32'(mc_req), 32'd0);

    // rdy_in low freezes state even with mc_done pending
    issue(4'd2, 1'b0, 2'b11, 1'b0, 32'h40, 32'h0, 4'd0, 4'd0, 32'd0);
    wait_req("rdy_req");
    rdy_in = 1'b0; mc_done = 1'b1; mc_rdata = 32'h77;
    repeat (2) begin
      step();
      chk("rdy_hold_req", 32'(mc_req), 32'd1);
      chk("rdy_hold_out", 32'(lsq_out_valid), 32'd0);
    end
    rdy_in = 1'b1;
    step();
    mc_done = 1'b0;
    chk("rdy_resume_valid", 32'(lsq_out_valid), 32'd1);
    chk("rdy_resume_result", lsq_out_result, 32'h77);
    chk("rdy_resume_tag", 32'(lsq_out_rob_index), 32'd2);

    // Asynchronous reset while BUSY
    issue(4'd3, 1'b0, 2'b11, 1'b0, 32'h80, 32'h0, 4'd0, 4'd0, 32'd0);
    wait_req("arst_req");
    rst_in = 1'b1;
    #1;
    chk("arst_mc_req", 32'(mc_req), 32'd0);
    chk("arst_addr", mc_addr, 32'd0);
    chk("arst_len", 32'(mc_len), 32'd0);
    chk("arst_out_result", lsq_out_result, 32'd0);
    chk("arst_out_tag", 32'(lsq_out_rob_index), 32'd0);
    chk("arst_full", 32'(lsq_full), 32'd0);
    step();
    rst_in = 1'b0;
    repeat (3) step();
    chk("arst_idle", 32'(mc_req), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_queue.md
LOAD_STORE_QUEUE -- requirements
Module: load_store_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning entry count; power of two, at least 2.
REQ-002 SHALL have parameter ROB_W, default 4, meaning ROB index width; index 0 means "no dependency".
REQ-003 SHALL have parameter DATA_W, default 32, meaning data and address width.
REQ-004 SHALL use one clock, clk_in; reset is asynchronous and active-high on rst_in.
REQ-005 clk_in  in  1  clock.
REQ-006 rst_in  in  1  asynchronous active-high reset.
REQ-007 rdy_in  in  1  global enable; low freezes all state.
REQ-008 clr_in  in  1  mispredict flush.
REQ-009 issue_valid  in  1  enqueue request.
REQ-010 issue_rob_index  in  ROB_W  ROB tag of the entry.
REQ-011 issue_is_store  in  1  1 = store, 0 = load.
REQ-012 issue_len  in  2  access size: 01 byte, 10 half, 11 word.
REQ-013 issue_unsigned  in  1  zero-extend load data.
REQ-014 issue_rs1_val, issue_rs2_val  in  DATA_W  operand values.
REQ-015 issue_rs1_depend, issue_rs2_depend  in  ROB_W  producer tags; 0 = operand ready.
REQ-016 issue_imm  in  DATA_W  address offset.
REQ-017 lsq_full  out  1  high when count == DEPTH.
REQ-018 alu_valid, alu_rob_index, alu_result  in  1/ROB_W/DATA_W  ALU broadcast.
REQ-019 commit_valid, commit_rob_index  in  1/ROB_W  ROB commit of a store.
REQ-020 mc_req, mc_is_store, mc_len, mc_addr, mc_wdata  out  1/1/2/DATA_W/DATA_W  memory request; held stable until mc_done.
REQ-021 mc_done, mc_rdata  in  1/DATA_W  one-cycle completion pulse and load data.
REQ-022 lsq_out_valid, lsq_out_result, lsq_out_rob_index  out  1/DATA_W/ROB_W  result broadcast.

Function
REQ-023 SHALL operate as a circular FIFO with head, tail and a count register, so that all DEPTH slots are usable.
REQ-024 SHALL accept an enqueue only when issue_valid && !lsq_full; a simultaneous enqueue and dequeue at count == DEPTH is refused.
REQ-025 SHALL wrap pointers modulo DEPTH.
REQ-026 Wakeup SHALL be registered: each entry whose depend tag equals a valid alu_rob_index or lsq_out_rob_index captures the value and clears the tag to 0.
REQ-027 Wakeup SHALL also bypass to the entry being enqueued in the same cycle.
REQ-028 A head load SHALL issue once both depend tags are 0, without waiting for commit.
REQ-029 A head store SHALL issue only when both depend tags are 0 and commit_valid && commit_rob_index matches its tag in that cycle, or the commit was latched earlier into a per-entry committed bit.
REQ-030 The FSM SHALL have three states.
REQ-031 IDLE: when the head is eligible, drive mc_req=1, mc_addr=rs1+imm (mod 2^DATA_W), mc_wdata=rs2, mc_len and mc_is_store; pop the head; go to BUSY. The request is visible in the cycle after eligibility.
REQ-032 BUSY: on mc_done, drop mc_req; lsq_out_valid=1 for exactly one cycle in the next cycle, carrying the rob tag; return to IDLE.
REQ-033 Load result SHALL be sign-extended from bit 7/15 unless issue_unsigned, in which case it is zero-extended.
REQ-034 Store result SHALL be 0.
REQ-035 clr_in SHALL empty the queue (head=tail, count=0).
REQ-036 If clr_in arrives in BUSY with a store in flight, the FSM SHALL go to DRAIN, keep mc_req until mc_done, suppress lsq_out_valid, then go to IDLE.
REQ-037 If clr_in arrives in BUSY with a load in flight, the FSM SHALL go to DRAIN and discard the data.
REQ-038 While in DRAIN, new issues SHALL be accepted and held.
REQ-039 If issue and clr_in occur together, the SHALL discard the issue.
REQ-040 While rdy_in is low, the block SHALL ignore all inputs and hold all state and outputs.

Reset
REQ-041 On asynchronous rst_in, the block SHALL set: state=IDLE, head=tail=count=0, mc_req=0, lsq_out_valid=0, lsq_full=0, all committed bits 0, all other outputs 0.
REQ-042 The block SHALL abandon any in-flight access on reset; the memory controller is reset by the same rst_in.

Structure
REQ-043 Length codes, the FSM state encoding and the default widths SHALL live in the shared definitions package.
REQ-044 Load extension SHALL be a sub-module, lsq_load_extend, which is combinational on len, unsigned and data.

Verification
REQ-045 Issue an LW with tag 3, rs1=0x100, imm=4, deps 0 -> mc_req with addr 0x104, len 11; mc_done with rdata 0xDEADBEEF -> next cycle lsq_out_valid, result 0xDEADBEEF, tag 3.
REQ-046 Issue an LB and then an LBU, each with rdata 0x80 -> results 0xFFFFFF80 and 0x00000080.
REQ-047 Issue an SW with tag 5 and rs2_depend=2; ALU broadcast tag 2 = 0x55, then commit tag 5 -> mc_req store, wdata 0x55, and no mc_req before the commit.
REQ-048 Fill all DEPTH entries -> lsq_full=1, the next issue is dropped; one pop -> lsq_full=0; pointer wrap exercised twice.
REQ-049 SW in flight, then clr_in -> mc_req held until mc_done, no lsq_out_valid, queue empty, and the next LW proceeds normally.
REQ-050 Assert rst_in mid-BUSY -> all outputs 0 immediately, without waiting for a clock edge.
